// File: rtl/ad9516_spi_responder_pkg.sv
// Shared definitions for the AD9516-style SPI register protocol, used by both
// the responder and the master-side control.
package ad9516_spi_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_e;

  localparam int RW_BIT = 15;
  localparam int W_MSB  = 14;
  localparam int W_LSB  = 13;
  localparam int ADDR_W = 13;

  // Streaming address step; wraps modulo 2^ADDR_W in either direction.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic dec);
    return dec ? addr - 1'b1 : addr + 1'b1;
  endfunction

endpackage

// File: rtl/ad9516_spi_responder_pin_sync.sv
// Equal-depth synchronizer for the SPI pins plus SCLK edge detection in the
// sys_clk domain.
module ad9516_spi_responder_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic sys_clk_i,
  input  logic rst_n_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_active_o,
  output logic mosi_s_o
);

  // Bit order per stage: {sclk, cs_n, mosi}.
  logic [2:0] pin_q [STAGES];
  logic       sclk_prev_q;

  // NOTE: cs_n resets to its active level (0) so a frame already in progress
  // at reset release can never look like a fresh CS fall.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) pin_q[i] <= 3'b000;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      pin_q[0] <= {sclk_i, cs_n_i, mosi_i};
      for (int i = 1; i < STAGES; i++) pin_q[i] <= pin_q[i-1];
      sclk_prev_q <= pin_q[STAGES-1][2];
    end
  end

  assign sclk_rise_o = pin_q[STAGES-1][2] & ~sclk_prev_q;
  assign sclk_fall_o = ~pin_q[STAGES-1][2] & sclk_prev_q;
  assign cs_active_o = ~pin_q[STAGES-1][1];
  assign mosi_s_o    = pin_q[STAGES-1][0];

endmodule

// File: rtl/ad9516_spi_responder.sv
// SPI slave for the AD9516 register protocol: 16-bit instruction then 1..4
// data bytes, bridged onto a one-cycle strobe parallel register bus.
module ad9516_spi_responder
  import ad9516_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ADDR_DEC    = 1'b1
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              busy_o,
  output logic              frame_err_o
);

  logic sclk_rise, sclk_fall, cs_active, mosi_s;

  ad9516_spi_responder_pin_sync #(.STAGES(SYNC_STAGES)) u_spi_pin_sync (
    .sys_clk_i  (sys_clk_i),
    .rst_n_i    (rst_n_i),
    .sclk_i     (sclk_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .cs_active_o(cs_active),
    .mosi_s_o   (mosi_s)
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d, w_q, w_d;
  logic [ADDR_W-1:0] addr_q, addr_d, reg_addr_q, reg_addr_d;
  logic [14:0]       shift_q, shift_d;
  logic [15:0]       shift_in;
  logic [7:0]        prefetch_q, wdata_q, wdata_d;
  logic              rd_dly_q, cs_act_prev_q, armed_q;
  logic              miso_q, miso_d, oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, ferr_q, ferr_d;
  logic              rise_ev, fall_ev;

  // A rise landing in the same sample as the CS rise still completes its byte.
  assign rise_ev  = sclk_rise & (cs_active | cs_act_prev_q);
  assign fall_ev  = sclk_fall & cs_active;
  assign shift_in = {shift_q, mosi_s};

  always_comb begin
    // NOTE: every next-state value defaults to hold (strobes to 0) before the
    // case, so no branch can leave a signal unassigned and infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    w_d        = w_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        miso_d     = 1'b0;
        oe_d       = 1'b0;
        if (cs_active && armed_q) state_d = ST_CMD;
      end
      ST_CMD: if (rise_ev) begin
        shift_d   = shift_in[14:0];
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          w_d    = shift_in[W_MSB:W_LSB];
          addr_d = shift_in[ADDR_W-1:0];
          if (shift_in[RW_BIT]) begin
            state_d    = ST_RDATA;
            rd_d       = 1'b1;
            reg_addr_d = shift_in[ADDR_W-1:0];
          end else begin
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: if (rise_ev) begin
        shift_d   = shift_in[14:0];
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          wr_d       = 1'b1;
          wdata_d    = shift_in[7:0];
          reg_addr_d = addr_q;
          addr_d     = step_addr(addr_q, ADDR_DEC);
          bit_cnt_d  = '0;
          if (byte_cnt_q == w_q) state_d = ST_DONE;
          else                   byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      ST_RDATA: begin
        if (fall_ev) begin
          if (bit_cnt_q == 4'd0) begin
            // First fall of a byte: present the prefetched byte, fetch the next.
            shift_d = {7'h00, prefetch_q};
            miso_d  = prefetch_q[7];
            oe_d    = 1'b1;
            if (byte_cnt_q != w_q) begin
              addr_d     = step_addr(addr_q, ADDR_DEC);
              reg_addr_d = step_addr(addr_q, ADDR_DEC);
              rd_d       = 1'b1;
            end
          end else begin
            shift_d = {shift_q[13:0], 1'b0};
            miso_d  = shift_q[6];
          end
        end
        if (rise_ev) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == w_q) state_d = ST_DONE;
            else                   byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !cs_active) begin
      ferr_d = (state_d == ST_CMD) ||
               ((state_d == ST_WDATA || state_d == ST_RDATA) && bit_cnt_d != 4'd0);
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      miso_d     = 1'b0;
      oe_d       = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      w_q           <= '0;
      addr_q        <= '0;
      shift_q       <= '0;
      reg_addr_q    <= '0;
      wdata_q       <= '0;
      prefetch_q    <= '0;
      rd_dly_q      <= 1'b0;
      cs_act_prev_q <= 1'b1;
      armed_q       <= 1'b0;
      miso_q        <= 1'b0;
      oe_q          <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      w_q           <= w_d;
      addr_q        <= addr_d;
      shift_q       <= shift_d;
      reg_addr_q    <= reg_addr_d;
      wdata_q       <= wdata_d;
      rd_dly_q      <= rd_q;
      if (rd_dly_q) prefetch_q <= reg_rdata_i;
      cs_act_prev_q <= cs_active;
      armed_q       <= armed_q | ~cs_active;
      miso_q        <= miso_d;
      oe_q          <= oe_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      ferr_q        <= ferr_d;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = oe_q;
  assign reg_wr_o    = wr_q;
  assign reg_rd_o    = rd_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = wdata_q;
  assign frame_err_o = ferr_q;
  // Busy only counts frames that began with a CS fall seen after reset.
  assign busy_o      = cs_active & armed_q;

endmodule

// File: tb/tb_ad9516_spi_responder.sv
// Scoreboard bench: a decrementing and an incrementing responder share SCLK/MOSI
// and have separate chip selects; an SPI master task drives both.
module tb_ad9516_spi_responder;

  localparam int HALF = 100;  // half SCLK period in ns; sys_clk period is 10 ns

  typedef struct packed {
    logic        rd;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic sys_clk, rst_n, sclk, mosi, cs_n0, cs_n1, sel_inc;
  logic miso0, oe0, wr0, rd0, busy0, ferr0;
  logic miso1, oe1, wr1, rd1, busy1, ferr1;
  logic [12:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, rdata0, rdata1;
  logic        miso_sel, oe_sel;

  exp_t exp_q0[$], exp_q1[$];
  int   checks = 0, errors = 0, cyc = 0, rise_cyc = 0, ferr_cnt0 = 0, ferr_cnt1 = 0;

  ad9516_spi_responder #(.SYNC_STAGES(2), .ADDR_DEC(1'b1)) u_dut_dec (
    .sys_clk_i(sys_clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n0), .mosi_i(mosi),
    .miso_o(miso0), .miso_oe_o(oe0), .reg_wr_o(wr0), .reg_rd_o(rd0), .reg_addr_o(addr0),
    .reg_wdata_o(wdata0), .reg_rdata_i(rdata0), .busy_o(busy0), .frame_err_o(ferr0)
  );

  ad9516_spi_responder #(.SYNC_STAGES(2), .ADDR_DEC(1'b0)) u_dut_inc (
    .sys_clk_i(sys_clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n1), .mosi_i(mosi),
    .miso_o(miso1), .miso_oe_o(oe1), .reg_wr_o(wr1), .reg_rd_o(rd1), .reg_addr_o(addr1),
    .reg_wdata_o(wdata1), .reg_rdata_i(rdata1), .busy_o(busy1), .frame_err_o(ferr1)
  );

  assign miso_sel = sel_inc ? miso1 : miso0;
  assign oe_sel   = sel_inc ? oe1 : oe0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // Register-map model: data valid the cycle after the read strobe.
  always @(posedge sys_clk) begin
    if (rd0) rdata0 <= (addr0 == 13'h010) ? 8'h3C : (addr0 == 13'h00F) ? 8'hC3 : 8'h00;
    if (rd1) rdata1 <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic score(input string tag, input logic wr, input logic rd,
                       input logic [12:0] addr, input logic [7:0] wdata, input exp_t e);
    check({tag, "_kind"}, {wr, rd}, e.rd ? 2'b01 : 2'b10);
    check({tag, "_addr"}, addr, e.addr);
    if (!e.rd) begin
      check({tag, "_wdata"}, wdata, e.data);
      check({tag, "_wr_latency"}, cyc - rise_cyc, 3);
    end
  endtask

  always @(negedge sys_clk) if (rst_n) begin
    if (wr0 || rd0) begin
      if (exp_q0.size() == 0) check("dec_unexpected_strobe", {wr0, rd0}, 2'b00);
      else score("dec", wr0, rd0, addr0, wdata0, exp_q0.pop_front());
    end
    if (wr1 || rd1) begin
      if (exp_q1.size() == 0) check("inc_unexpected_strobe", {wr1, rd1}, 2'b00);
      else score("inc", wr1, rd1, addr1, wdata1, exp_q1.pop_front());
    end
    if (ferr0) ferr_cnt0++;
    if (ferr1) ferr_cnt1++;
  end

  task automatic set_cs(input logic level);
    if (sel_inc) cs_n1 = level;
    else         cs_n0 = level;
  endtask

  // Mode 0: MOSI changes while SCLK is low, both sides sample on the rise.
  task automatic xfer_bits(input logic [7:0] tx, input int n,
                           output logic [7:0] rx, output int oe_hi);
    rx = 8'h00;
    oe_hi = 0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #(HALF);
      sclk = 1'b1;
      rise_cyc = cyc;
      rx = {rx[6:0], miso_sel};
      oe_hi += int'(oe_sel);
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] instr, input int nbytes, input logic [31:0] tx,
                       output logic [31:0] rx, output int oe_cmd, output int oe_data);
    logic [7:0] b;
    int o;
    set_cs(1'b0);
    #(HALF);
    xfer_bits(instr[15:8], 8, b, o); oe_cmd = o;
    xfer_bits(instr[7:0], 8, b, o);  oe_cmd += o;
    rx = '0;
    oe_data = 0;
    for (int k = 0; k < nbytes; k++) begin
      xfer_bits(tx[31-8*k -: 8], 8, b, o);
      rx = {rx[23:0], b};
      oe_data += o;
    end
    #(HALF);
    set_cs(1'b1);
    #(4*HALF);
  endtask

  initial begin
    #(500_000);
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [7:0]  b;
    int oc, od, o;
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n0 = 1'b1; cs_n1 = 1'b1; sel_inc = 1'b0;
    rdata0 = 8'h00; rdata1 = 8'h00;
    #23;
    check("reset_outputs", {miso0, oe0, wr0, rd0, addr0, wdata0, busy0, ferr0}, 0);
    #7 rst_n = 1'b1;
    @(posedge sys_clk); #2;
    #(4*HALF);

    // Single-byte write.
    exp_q0.push_back('{1'b0, 13'h232, 8'hA5});
    frame(16'h0232, 1, 32'hA500_0000, rx, oc, od);
    check("wr1_ferr", ferr_cnt0, 0);
    check("wr1_busy_idle", busy0, 1'b0);

    // Two-byte read with decrementing address.
    exp_q0.push_back('{1'b1, 13'h010, 8'h00});
    exp_q0.push_back('{1'b1, 13'h00F, 8'h00});
    frame(16'hA010, 2, 32'h0, rx, oc, od);
    check("rd2_data", rx[15:0], 16'h3CC3);
    check("rd2_oe_cmd", oc, 0);
    check("rd2_oe_data", od, 16);
    check("rd2_oe_after", oe0, 1'b0);

    // Streaming write, W=3, both address directions.
    exp_q0.push_back('{1'b0, 13'h0000, 8'h11});
    exp_q0.push_back('{1'b0, 13'h1FFF, 8'h22});
    exp_q0.push_back('{1'b0, 13'h1FFE, 8'h33});
    exp_q0.push_back('{1'b0, 13'h1FFD, 8'h44});
    frame(16'h6000, 4, 32'h1122_3344, rx, oc, od);
    sel_inc = 1'b1;
    exp_q1.push_back('{1'b0, 13'h000, 8'h11});
    exp_q1.push_back('{1'b0, 13'h001, 8'h22});
    exp_q1.push_back('{1'b0, 13'h002, 8'h33});
    exp_q1.push_back('{1'b0, 13'h003, 8'h44});
    frame(16'h6000, 4, 32'h1122_3344, rx, oc, od);
    sel_inc = 1'b0;
    check("stream_ferr_inc", ferr_cnt1, 0);

    // Abort after five data bits, then a normal frame.
    set_cs(1'b0); #(HALF);
    xfer_bits(8'h00, 8, b, o);
    xfer_bits(8'h05, 8, b, o);
    xfer_bits(8'hFF, 5, b, o);
    #(HALF); set_cs(1'b1); #(4*HALF);
    check("abort_ferr", ferr_cnt0, 1);
    exp_q0.push_back('{1'b0, 13'h005, 8'h5A});
    frame(16'h0005, 1, 32'h5A00_0000, rx, oc, od);
    check("after_abort_ferr", ferr_cnt0, 1);

    // Overclocked tail: four extra SCLK pulses after a one-byte write.
    exp_q0.push_back('{1'b0, 13'h1ABC, 8'h7E});
    set_cs(1'b0); #(HALF);
    xfer_bits(8'h1A, 8, b, o);
    xfer_bits(8'hBC, 8, b, o);
    xfer_bits(8'h7E, 8, b, o);
    xfer_bits(8'hFF, 4, b, o);
    check("tail_busy_high", busy0, 1'b1);
    #(HALF); set_cs(1'b1); #50;
    check("tail_busy_low", busy0, 1'b0);
    #(4*HALF);
    check("tail_ferr", ferr_cnt0, 1);

    // Reset in the middle of read byte 1; remainder of frame must be ignored.
    exp_q0.push_back('{1'b1, 13'h010, 8'h00});
    exp_q0.push_back('{1'b1, 13'h00F, 8'h00});
    set_cs(1'b0); #(HALF);
    xfer_bits(8'hA0, 8, b, o);
    xfer_bits(8'h10, 8, b, o);
    xfer_bits(8'h00, 3, b, o);
    rst_n = 1'b0;
    #3;
    check("midreset_outputs", {miso0, oe0, wr0, rd0, addr0, wdata0, busy0, ferr0}, 0);
    #27 rst_n = 1'b1;
    xfer_bits(8'h00, 5, b, o);
    check("midreset_oe_ignored", o, 0);
    xfer_bits(8'h00, 8, b, o);
    check("midreset_busy_ignored", busy0, 1'b0);
    #(HALF); set_cs(1'b1); #(4*HALF);
    check("midreset_ferr", ferr_cnt0, 1);
    exp_q0.push_back('{1'b1, 13'h010, 8'h00});
    exp_q0.push_back('{1'b1, 13'h00F, 8'h00});
    frame(16'hA010, 2, 32'h0, rx, oc, od);
    check("post_reset_rd_data", rx[15:0], 16'h3CC3);

    check("dec_scoreboard_drained", exp_q0.size(), 0);
    check("inc_scoreboard_drained", exp_q1.size(), 0);
    check("inc_ferr_total", ferr_cnt1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
